// File: rtl/fpu_op_sequencer_if.sv
// rtl/fpu_op_sequencer_if.sv - operand-entry / FPU-core handshake bundle for fpu_op_sequencer
interface fpu_op_sequencer_if;
    logic        clr;
    logic        save;
    logic [7:0]  datain;
    logic        core_done;
    logic [31:0] core_result;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        core_start;
    logic [31:0] result;
    logic        result_valid;
    logic        error;
    logic [2:0]  state_code;
    logic [1:0]  byte_idx;

    modport master (
        output clr, save, datain, core_done, core_result,
        input  op_a, op_b, core_start, result, result_valid, error, state_code, byte_idx
    );

    modport slave (
        input  clr, save, datain, core_done, core_result,
        output op_a, op_b, core_start, result, result_valid, error, state_code, byte_idx
    );
endinterface

// File: rtl/fpu_op_sequencer.sv
// rtl/fpu_op_sequencer.sv - byte-wise operand loader that launches an FPU core and captures its result
module fpu_op_sequencer #(
    parameter int TIMEOUT = 1024
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    fpu_op_sequencer_if.slave    bus
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_LOAD_A = 3'd0,
        S_LOAD_B = 3'd1,
        S_START  = 3'd2,
        S_WAIT   = 3'd3,
        S_DONE   = 3'd4,
        S_ERR    = 3'd5
    } state_e;

    state_e        state_q, state_d;
    logic [1:0]    byte_idx_q, byte_idx_d;
    logic [31:0]   op_a_q, op_a_d;
    logic [31:0]   op_b_q, op_b_d;
    logic [31:0]   result_q, result_d;
    logic          valid_q, valid_d;
    logic          error_q, error_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sync1_q, sync2_q, edge_q;
    logic          commit;

    // save is a raw button level: two flops for metastability, one for edge detect
    assign commit = sync2_q & ~edge_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_LOAD_A;
            byte_idx_q <= '0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            result_q   <= '0;
            valid_q    <= 1'b0;
            error_q    <= 1'b0;
            cnt_q      <= '0;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            edge_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            result_q   <= result_d;
            valid_q    <= valid_d;
            error_q    <= error_d;
            cnt_q      <= cnt_d;
            sync1_q    <= bus.save;
            sync2_q    <= sync1_q;
            edge_q     <= sync2_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        result_d   = result_q;
        valid_d    = valid_q;
        error_d    = error_q;
        cnt_d      = cnt_q;
        if (bus.clr) begin
            // abort keeps the last displayed result but drops its valid flag
            state_d    = S_LOAD_A;
            byte_idx_d = '0;
            op_a_d     = '0;
            op_b_d     = '0;
            error_d    = 1'b0;
            valid_d    = 1'b0;
        end else begin
            unique case (state_q)
                S_LOAD_A, S_LOAD_B: begin
                    if (commit) begin
                        if (state_q == S_LOAD_A) op_a_d[{byte_idx_q, 3'b000} +: 8] = bus.datain;
                        else                     op_b_d[{byte_idx_q, 3'b000} +: 8] = bus.datain;
                        byte_idx_d = byte_idx_q + 2'd1;
                        if (byte_idx_q == 2'd3) state_d = (state_q == S_LOAD_A) ? S_LOAD_B : S_START;
                    end
                end
                S_START: begin
                    cnt_d   = '0;
                    valid_d = 1'b0;
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    // a result arriving on the last allowed cycle still counts as success
                    if (bus.core_done) begin
                        result_d = bus.core_result;
                        valid_d  = 1'b1;
                        state_d  = S_DONE;
                    end else if (cnt_q == CNT_LAST) begin
                        error_d = 1'b1;
                        state_d = S_ERR;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_DONE, S_ERR: begin
                    if (commit) begin
                        state_d    = S_LOAD_A;
                        error_d    = 1'b0;
                        byte_idx_d = '0;
                    end
                end
                default: state_d = S_LOAD_A;
            endcase
        end
    end

    assign bus.op_a         = op_a_q;
    assign bus.op_b         = op_b_q;
    assign bus.core_start   = (state_q == S_START);
    assign bus.result       = result_q;
    assign bus.result_valid = valid_q;
    assign bus.error        = error_q;
    assign bus.state_code   = state_q;
    assign bus.byte_idx     = byte_idx_q;
endmodule
